// File: rtl/alu_stage_if.sv
// Operand/handshake bundle between the register-file control logic and alu_stage.
// MainBus is tri-stated and stays a plain top-level inout on alu_stage.
interface alu_stage_if;
  logic [7:0] LHSBus;
  logic [7:0] RHSBus;
  logic [3:0] op;
  logic       op_valid;
  logic       op_ready;
  logic       a_main_n;
  logic       result_valid;
  logic [3:0] flags;

  modport master (
    output LHSBus, RHSBus, op, op_valid, a_main_n,
    input  op_ready, result_valid, flags
  );

  modport slave (
    input  LHSBus, RHSBus, op, op_valid, a_main_n,
    output op_ready, result_valid, flags
  );
endinterface

// File: rtl/alu_stage.sv
// Two-slot pipelined 8-bit ALU: S1 latches operands/op, S2 holds the result and flags.
// The result is driven onto MainBus while a_main_n is low.
module alu_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  alu_stage_if.slave       bus,
  inout  wire  [WIDTH-1:0] MainBus
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBC = 4'd3,
    OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7,
    OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_ROL = 4'd10, OP_ROR = 4'd11,
    OP_INC = 4'd12, OP_DEC = 4'd13, OP_CMP = 4'd14, OP_PASS = 4'd15
  } op_e;

  logic             s1_full_q, s1_full_d;
  logic [WIDTH-1:0] s1_l_q, s1_l_d;
  logic [WIDTH-1:0] s1_r_q, s1_r_d;
  op_e              s1_op_q, s1_op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic [3:0]       flags_q, flags_d;

  logic             consume_s, advance_s, accept_s, ready_s;
  logic [WIDTH-1:0] add_b_s, alu_res_s;
  logic             add_cin_s, alu_c_s, alu_v_s;
  logic [WIDTH:0]   sum_s;
  logic [3:0]       alu_flags_s;

  // Handshake: S1 may drain into S2 if S2 is free, being consumed now, or the op is CMP.
  always_comb begin
    consume_s = ~bus.a_main_n;
    advance_s = s1_full_q && (!res_valid_q || consume_s || (s1_op_q == OP_CMP));
    ready_s   = !s1_full_q || advance_s;
    accept_s  = bus.op_valid && ready_s;
  end

  // Adder operand selection; subtraction adds the complement with carry-in.
  always_comb begin
    add_b_s   = 8'h00;
    add_cin_s = 1'b0;
    case (s1_op_q)
      OP_ADD:         begin add_b_s = s1_r_q;  add_cin_s = 1'b0;       end
      OP_ADC:         begin add_b_s = s1_r_q;  add_cin_s = flags_q[0]; end
      OP_SUB, OP_CMP: begin add_b_s = ~s1_r_q; add_cin_s = 1'b1;       end
      OP_SBC:         begin add_b_s = ~s1_r_q; add_cin_s = flags_q[0]; end
      OP_INC:         begin add_b_s = 8'h00;   add_cin_s = 1'b1;       end
      OP_DEC:         begin add_b_s = 8'hFF;   add_cin_s = 1'b0;       end
      default:        begin add_b_s = 8'h00;   add_cin_s = 1'b0;       end
    endcase
    sum_s = {1'b0, s1_l_q} + {1'b0, add_b_s} + {8'h00, add_cin_s};
  end

  // Result and C/V per op; Z and N derive from the result for every op.
  always_comb begin
    alu_res_s = sum_s[7:0];
    alu_c_s   = sum_s[8];
    alu_v_s   = (s1_l_q[7] == add_b_s[7]) && (sum_s[7] != s1_l_q[7]);
    case (s1_op_q)
      OP_AND:  begin alu_res_s = s1_l_q & s1_r_q; alu_c_s = 1'b0; alu_v_s = 1'b0; end
      OP_OR:   begin alu_res_s = s1_l_q | s1_r_q; alu_c_s = 1'b0; alu_v_s = 1'b0; end
      OP_XOR:  begin alu_res_s = s1_l_q ^ s1_r_q; alu_c_s = 1'b0; alu_v_s = 1'b0; end
      OP_NOT:  begin alu_res_s = ~s1_l_q;         alu_c_s = 1'b0; alu_v_s = 1'b0; end
      OP_PASS: begin alu_res_s = s1_r_q;          alu_c_s = 1'b0; alu_v_s = 1'b0; end
      OP_SHL:  begin alu_res_s = {s1_l_q[6:0], 1'b0};       alu_c_s = s1_l_q[7]; alu_v_s = 1'b0; end
      OP_SHR:  begin alu_res_s = {1'b0, s1_l_q[7:1]};       alu_c_s = s1_l_q[0]; alu_v_s = 1'b0; end
      OP_ROL:  begin alu_res_s = {s1_l_q[6:0], flags_q[0]}; alu_c_s = s1_l_q[7]; alu_v_s = 1'b0; end
      OP_ROR:  begin alu_res_s = {flags_q[0], s1_l_q[7:1]}; alu_c_s = s1_l_q[0]; alu_v_s = 1'b0; end
      default: begin alu_res_s = sum_s[7:0]; alu_c_s = sum_s[8];
                     alu_v_s = (s1_l_q[7] == add_b_s[7]) && (sum_s[7] != s1_l_q[7]); end
    endcase
    alu_flags_s = {alu_v_s, alu_res_s[7], (alu_res_s == 8'h00), alu_c_s};
  end

  // Next-state for both slots; an advance setting result_valid wins over a consume.
  always_comb begin
    s1_full_d   = s1_full_q;
    s1_l_d      = s1_l_q;
    s1_r_d      = s1_r_q;
    s1_op_d     = s1_op_q;
    res_d       = res_q;
    res_valid_d = res_valid_q && !consume_s;
    flags_d     = flags_q;
    if (advance_s) begin
      flags_d   = alu_flags_s;
      s1_full_d = 1'b0;
      if (s1_op_q != OP_CMP) begin
        res_d       = alu_res_s;
        res_valid_d = 1'b1;
      end else begin
        res_d = res_q;
      end
    end else begin
      s1_full_d = s1_full_q;
    end
    if (accept_s) begin
      s1_full_d = 1'b1;
      s1_l_d    = bus.LHSBus;
      s1_r_d    = bus.RHSBus;
      s1_op_d   = op_e'(bus.op);
    end else begin
      s1_op_d = s1_op_q;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_full_q   <= 1'b0;
      s1_l_q      <= 8'h00;
      s1_r_q      <= 8'h00;
      s1_op_q     <= OP_ADD;
      res_q       <= 8'h00;
      res_valid_q <= 1'b0;
      flags_q     <= 4'h0;
    end else begin
      s1_full_q   <= s1_full_d;
      s1_l_q      <= s1_l_d;
      s1_r_q      <= s1_r_d;
      s1_op_q     <= s1_op_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.op_ready     = ready_s;
  assign bus.result_valid = res_valid_q;
  assign bus.flags        = flags_q;
  assign MainBus = (!bus.a_main_n && !reset) ? res_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_stage.sv
// Directed bench for alu_stage: a vector table for every op plus hand-written
// sequences for back-to-back issue, backpressure and mid-operation reset.
module tb_alu_stage;
  logic       clk;
  logic       reset;
  wire  [7:0] main_bus;
  int         n_total;
  int         n_pass;

  alu_stage_if bus_if ();

  alu_stage #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if.slave),
    .MainBus (main_bus)
  );

  // Undriven MainBus reads as 0xFF.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (main_bus[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] l;
    logic [7:0] r;
    logic [7:0] exp_res;
    logic [3:0] exp_flags;
    logic       exp_valid;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [7:0] l, input logic [7:0] r,
                       input logic [3:0] o, input logic amn);
    bus_if.op_valid = v;
    bus_if.LHSBus   = l;
    bus_if.RHSBus   = r;
    bus_if.op       = o;
    bus_if.a_main_n = amn;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    // op, L, R, result, {V,N,Z,C}, result_valid; flags chain from row to row
    vecs[0]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 4'h3, 1'b1}; // ADD
    vecs[1]  = '{4'd1,  8'h10, 8'h20, 8'h31, 4'h0, 1'b1}; // ADC C=1
    vecs[2]  = '{4'd2,  8'h05, 8'h07, 8'hFE, 4'h4, 1'b1}; // SUB borrow
    vecs[3]  = '{4'd14, 8'h80, 8'h01, 8'hFE, 4'h9, 1'b0}; // CMP keeps result
    vecs[4]  = '{4'd3,  8'h50, 8'h10, 8'h40, 4'h1, 1'b1}; // SBC C=1
    vecs[5]  = '{4'd4,  8'hF0, 8'h3C, 8'h30, 4'h0, 1'b1}; // AND
    vecs[6]  = '{4'd5,  8'h0F, 8'hF0, 8'hFF, 4'h4, 1'b1}; // OR
    vecs[7]  = '{4'd6,  8'hAA, 8'hAA, 8'h00, 4'h2, 1'b1}; // XOR
    vecs[8]  = '{4'd7,  8'h55, 8'h00, 8'hAA, 4'h4, 1'b1}; // NOT
    vecs[9]  = '{4'd8,  8'h81, 8'h00, 8'h02, 4'h1, 1'b1}; // SHL
    vecs[10] = '{4'd9,  8'h01, 8'h00, 8'h00, 4'h3, 1'b1}; // SHR
    vecs[11] = '{4'd10, 8'h81, 8'h00, 8'h03, 4'h1, 1'b1}; // ROL C=1
    vecs[12] = '{4'd11, 8'h02, 8'h00, 8'h81, 4'h4, 1'b1}; // ROR C=1
    vecs[13] = '{4'd12, 8'h7F, 8'h00, 8'h80, 4'hC, 1'b1}; // INC overflow
    vecs[14] = '{4'd13, 8'h00, 8'h00, 8'hFF, 4'h4, 1'b1}; // DEC wrap
    vecs[15] = '{4'd15, 8'h12, 8'h00, 8'h00, 4'h2, 1'b1}; // PASS
    vecs[16] = '{4'd0,  8'h7F, 8'h01, 8'h80, 4'hC, 1'b1}; // ADD overflow
    vecs[17] = '{4'd10, 8'h81, 8'h00, 8'h02, 4'h1, 1'b1}; // ROL C=0
    vecs[18] = '{4'd11, 8'h02, 8'h00, 8'h81, 4'h4, 1'b1}; // ROR C=1

    reset = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0);
    tick();
    tick();
    chk("reset_bus_z", main_bus, 8'hFF);
    chk("reset_flags", bus_if.flags, 4'h0);
    chk("reset_valid", bus_if.result_valid, 1'b0);
    chk("reset_ready", bus_if.op_ready, 1'b1);
    reset = 1'b0;
    #1;
    chk("reset_res_on_bus", main_bus, 8'h00);
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      drive(1'b1, vecs[i].l, vecs[i].r, vecs[i].op, 1'b0);
      tick();
      drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0);
      tick();
      #1;
      chk($sformatf("vec%0d_res", i), main_bus, vecs[i].exp_res);
      chk($sformatf("vec%0d_flags", i), bus_if.flags, vecs[i].exp_flags);
      chk($sformatf("vec%0d_valid", i), bus_if.result_valid, vecs[i].exp_valid);
      @(negedge clk);
    end

    // back-to-back ADD then ADC, consuming every edge
    drive(1'b1, 8'hFF, 8'h01, 4'd0, 1'b0);
    tick();
    drive(1'b1, 8'h10, 8'h20, 4'd1, 1'b0);
    #1;
    chk("b2b_ready", bus_if.op_ready, 1'b1);
    tick();
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0);
    #1;
    chk("b2b_add_res", main_bus, 8'h00);
    chk("b2b_add_flags", bus_if.flags, 4'h3);
    tick();
    #1;
    chk("b2b_adc_res", main_bus, 8'h31);
    chk("b2b_adc_flags", bus_if.flags, 4'h0);
    tick();

    // backpressure: two accepted, third stalls until a one-cycle consume
    drive(1'b1, 8'h00, 8'h11, 4'd15, 1'b1);
    tick();
    drive(1'b1, 8'h00, 8'h22, 4'd15, 1'b1);
    #1;
    chk("bp_ready2", bus_if.op_ready, 1'b1);
    tick();
    drive(1'b1, 8'h00, 8'h33, 4'd15, 1'b1);
    #1;
    chk("bp_ready3_low", bus_if.op_ready, 1'b0);
    chk("bp_valid", bus_if.result_valid, 1'b1);
    chk("bp_bus_z", main_bus, 8'hFF);
    tick();
    drive(1'b1, 8'h00, 8'h33, 4'd15, 1'b0);
    #1;
    chk("bp_ready_on_consume", bus_if.op_ready, 1'b1);
    chk("bp_first_res", main_bus, 8'h11);
    tick();
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b1);
    #1;
    chk("bp_valid_after", bus_if.result_valid, 1'b1);
    chk("bp_ready_after", bus_if.op_ready, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0);
    #1;
    chk("bp_second_res", main_bus, 8'h22);
    tick();
    #1;
    chk("bp_third_res", main_bus, 8'h33);
    chk("bp_third_valid", bus_if.result_valid, 1'b1);
    tick();
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b1);
    #1;
    chk("bp_drained", bus_if.result_valid, 1'b0);

    // reset while S1 full and result_valid set; ADD leaves C=1 beforehand
    drive(1'b1, 8'hFF, 8'h01, 4'd0, 1'b1);
    tick();
    drive(1'b1, 8'h01, 8'h01, 4'd0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b1);
    #1;
    chk("pre_rst_valid", bus_if.result_valid, 1'b1);
    chk("pre_rst_ready", bus_if.op_ready, 1'b0);
    chk("pre_rst_flags", bus_if.flags, 4'h3);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_valid", bus_if.result_valid, 1'b0);
    chk("rst_ready", bus_if.op_ready, 1'b1);
    chk("rst_flags", bus_if.flags, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 8'h10, 8'h20, 4'd1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0);
    tick();
    #1;
    chk("post_rst_adc_res", main_bus, 8'h30);
    chk("post_rst_adc_flags", bus_if.flags, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
